// File: rtl/alu_wb_sequencer.sv
// alu_wb_sequencer: four-state read/execute/write-back ALU sequencer around an external register file.
// Define ALU_WB_SHIFT_EN to make ALU_OP 111 a logical left shift; otherwise it is flagged as illegal.
module alu_wb_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        ALU_OP,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [ADDR_W-1:0] Rd,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic              Busy,
    output logic              Done,
    output logic              ZF,
    output logic              OF,
    output logic              Err
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    localparam int MSB = DATA_W - 1;
    state_t state, state_n;
    logic [2:0] op_q;
    logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, res, sum, diff;
    logic of, err, lt;
`ifdef ALU_WB_SHIFT_EN
    localparam int SH_W = $clog2(DATA_W);
`endif

    always_ff @(posedge Clk)
        state <= Reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = Start ? READ : IDLE;
            READ:    state_n = EXEC;
            EXEC:    state_n = WB;
            default: state_n = IDLE;
        endcase
        Busy      = state != IDLE;
        Done      = state == WB;
        R_Addr_A  = state == READ ? rs_q : '0;
        R_Addr_B  = state == READ ? rt_q : '0;
        W_Addr    = state == WB ? rd_q : '0;
        W_Data    = state == WB ? res_q : '0;
        Write_Reg = state == WB && rd_q != '0 && !Err;
    end

    always_comb begin
        sum  = a_q + b_q;
        diff = a_q - b_q;
        lt   = $signed(a_q) < $signed(b_q);
        err  = 1'b0;
        res  = '0;
        case (op_q)
            3'b000: res = a_q & b_q;
            3'b001: res = a_q | b_q;
            3'b010: res = a_q ^ b_q;
            3'b011: res = ~(a_q | b_q);
            3'b100: res = sum;
            3'b101: res = diff;
            3'b110: res = {{(DATA_W-1){1'b0}}, lt};
`ifdef ALU_WB_SHIFT_EN
            default: res = b_q << a_q[SH_W-1:0];
`else
            default: err = 1'b1;
`endif
        endcase
        // signed overflow: operands' signs make the true result unrepresentable
        of = op_q == 3'b100 ? (a_q[MSB] == b_q[MSB] && sum[MSB] != a_q[MSB]) :
             op_q == 3'b101 ? (a_q[MSB] != b_q[MSB] && diff[MSB] != a_q[MSB]) : 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            ZF    <= 1'b0;
            OF    <= 1'b0;
            Err   <= 1'b0;
        end else begin
            if (state == IDLE && Start) begin
                op_q <= ALU_OP;
                rs_q <= Rs;
                rt_q <= Rt;
                rd_q <= Rd;
            end
            if (state == READ) begin
                a_q <= R_Data_A;
                b_q <= R_Data_B;
            end
            if (state == EXEC) begin
                res_q <= res;
                ZF    <= res == '0;
                OF    <= of;
                Err   <= err;
            end
        end
    end
endmodule

// File: doc/alu_wb_sequencer.md
ALU_WB_SEQUENCER -- requirements
Module: alu_wb_sequencer

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: ADDR_W, 5, register address width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 Start  input  1  request to execute one operation; sampled only in IDLE.
REQ-006 ALU_OP  input  3  operation code (see REQ-014).
REQ-007 Rs, Rt, Rd  input  ADDR_W each  source A, source B and destination register addresses.
REQ-008 R_Addr_A, R_Addr_B  output  ADDR_W  read addresses to the register file.
REQ-009 R_Data_A, R_Data_B  input  DATA_W  combinational read data returned by the register file.
REQ-010 W_Addr  output  ADDR_W; W_Data  output  DATA_W; Write_Reg  output  1  register file write port.
REQ-011 Busy  output  1  high whenever state is not IDLE.
REQ-012 Done  output  1  one-cycle pulse in WB.
REQ-013 ZF, OF, Err  output  1 each  zero, signed overflow, illegal-op flags of the last completed operation.

Function
REQ-014 ALU_OP: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB (A-B), 110 SLT (signed, result 0 or 1), 111 SLL (B << A[4:0]).
REQ-015 FSM states IDLE -> READ -> EXEC -> WB -> IDLE; all transitions unconditional except IDLE -> READ, taken when Start=1.
REQ-016 On IDLE exit, ALU_OP, Rs, Rt, Rd are latched; later input changes do not affect the operation.
REQ-017 READ: R_Addr_A=latched Rs, R_Addr_B=latched Rt; R_Data_A/B captured into operand registers at end of READ.
REQ-018 EXEC: result, ZF, OF, Err computed from operand registers and registered at end of EXEC.
REQ-019 WB: W_Addr=latched Rd, W_Data=result, Write_Reg=1, Done=1 for exactly one cycle.
REQ-020 Latency: Start sampled at edge N -> WB (Write_Reg, Done) during cycle N+3 -> Busy low from edge N+4.
REQ-021 Start while Busy=1 is ignored (no queueing); next Start accepted in IDLE, earliest one cycle after WB.
REQ-022 Rd=0: Write_Reg stays 0 in WB; Done still pulses; flags still update.
REQ-023 Arithmetic is modulo 2^DATA_W; OF set only for ADD/SUB signed overflow, else 0; ZF=1 iff result==0.
REQ-024 Outside WB: Write_Reg=0, W_Addr=0, W_Data=0; outside READ: R_Addr_A=R_Addr_B=0.
REQ-025 ZF, OF, Err hold their value until the next EXEC.

Reset
REQ-026 Reset=1 forces IDLE and Busy=0, Done=0, Write_Reg=0, W_Addr=0, W_Data=0, R_Addr_A=R_Addr_B=0, ZF=OF=Err=0, operand/result registers=0.
REQ-027 Reset overrides Start in the same cycle; reset in READ/EXEC/WB aborts with no register-file write after the reset edge.

Configuration
REQ-028 Macro ALU_WB_SHIFT_EN defined: ALU_OP 111 performs SLL, Err=0.
REQ-029 Macro undefined: ALU_OP 111 is illegal -> result 0, Err=1, Write_Reg stays 0 in WB, Done still pulses, no shifter logic synthesised.

Verification
REQ-030 Bench register model r1=0x11111111, r2=0x22222222; ADD Rs=1 Rt=2 Rd=3 -> cycle N+3 Write_Reg=1, W_Addr=3, W_Data=0x33333333, Done=1, ZF=0, OF=0.
REQ-031 r4=0x7FFFFFFF, r5=0x00000001; ADD Rs=4 Rt=5 Rd=6 -> W_Data=0x80000000, OF=1; SUB Rs=1 Rt=1 Rd=7 -> W_Data=0, ZF=1.
REQ-032 SLT Rs=4(0x7FFFFFFF) Rt=6(0x80000000) -> W_Data=0; Rd=0 any op -> Write_Reg never 1, Done pulses once.
REQ-033 Start held high 6 cycles -> exactly one op per IDLE visit, Start during Busy ignored, second WB at cycle N+7.
REQ-034 Reset asserted in EXEC -> Busy=0, Write_Reg=0 next cycle, no write to Rd, flags=0.
REQ-035 ALU_OP=111, r8=4, r2=0x22222222 -> with ALU_WB_SHIFT_EN W_Data=0x22222220; without it Err=1, Write_Reg=0.
